// File: rtl/lb_pkg.sv
// Shared constants and helpers for the lb_mem_1r1w line-buffer memory.
//
// Contents:
//   LB_DEPTH_DEF, LB_WIDTH_DEF, LB_MASK_GRAN_DEF  default geometry
//   LB_MAX_W                                      widest data word lb_expand_mask handles
//   lb_addr_w(depth)                              address width for a given depth
//   lb_expand_mask(mask, gran)                    lane mask -> bit-level mask
package lb_pkg;

  localparam int unsigned LB_DEPTH_DEF     = 32;
  localparam int unsigned LB_WIDTH_DEF     = 128;
  localparam int unsigned LB_MASK_GRAN_DEF = 8;

  // Upper bound on WIDTH for any instance; callers size-cast the result down.
  localparam int unsigned LB_MAX_W = 1024;

  function automatic int unsigned lb_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Replicates each lane-enable bit across its gran data bits. The mask argument is
  // zero-extended by the caller, so unused upper lanes come back as zero.
  function automatic logic [LB_MAX_W-1:0] lb_expand_mask(
    input logic [LB_MAX_W-1:0] mask,
    input int unsigned         gran = LB_MASK_GRAN_DEF
  );
    logic [LB_MAX_W-1:0] bits;
    bits = '0;
    for (int unsigned i = 0; i < LB_MAX_W; i++) begin
      bits[i] = mask[i / gran];
    end
    return bits;
  endfunction

endpackage

// File: rtl/lb_mem_1r1w_if.sv
// Bus bundle for lb_mem_1r1w: write port W0, read port R0, flush and read results.
//
// Parameters: DEPTH, WIDTH, MASK_GRAN (must match the memory instance).
// Signals:
//   W0_en, W0_addr[AW], W0_data[WIDTH], W0_mask[NLANES]  write request
//   R0_en, R0_addr[AW]                                   read request
//   flush                                                invalidate all entries
//   R0_valid, R0_data[WIDTH], R0_hit                     read result
// Modports: master (requester side), slave (memory side).
interface lb_mem_1r1w_if
  import lb_pkg::*;
#(
  parameter int unsigned DEPTH     = LB_DEPTH_DEF,
  parameter int unsigned WIDTH     = LB_WIDTH_DEF,
  parameter int unsigned MASK_GRAN = LB_MASK_GRAN_DEF
);

  localparam int unsigned AW     = lb_addr_w(DEPTH);
  localparam int unsigned NLANES = WIDTH / MASK_GRAN;

  logic              W0_en;
  logic [AW-1:0]     W0_addr;
  logic [WIDTH-1:0]  W0_data;
  logic [NLANES-1:0] W0_mask;
  logic              R0_en;
  logic [AW-1:0]     R0_addr;
  logic              flush;
  logic              R0_valid;
  logic [WIDTH-1:0]  R0_data;
  logic              R0_hit;

  modport master (
    output W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr, flush,
    input  R0_valid, R0_data, R0_hit
  );

  modport slave (
    input  W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr, flush,
    output R0_valid, R0_data, R0_hit
  );

endinterface

// File: rtl/lb_mem_array.sv
// Plain DEPTH x WIDTH storage with bit-level write enable and an unregistered read.
// This is the point where an SRAM macro wrapper can be substituted; the array has no
// reset and knows nothing about valid bits or address ranges.
//
// Ports:
//   clock      clock
//   we_i       write enable (caller guarantees waddr_i < DEPTH when set)
//   waddr_i    write address
//   wbit_en_i  per-bit write enable
//   wdata_i    write data
//   raddr_i    read address (result is don't-care when out of range)
//   rdata_o    combinational read data
module lb_mem_array
  import lb_pkg::*;
#(
  parameter int unsigned DEPTH = LB_DEPTH_DEF,
  parameter int unsigned WIDTH = LB_WIDTH_DEF,
  parameter int unsigned AW    = lb_addr_w(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wbit_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= (mem_q[waddr_i] & ~wbit_en_i) | (wdata_i & wbit_en_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lb_mem_1r1w.sv
// Parametrised single-clock 1-read/1-write line-buffer memory.
//
// Owns the per-entry valid bits, zero-fill of unmasked lanes on first write, range
// checks, same-address read/write handling and the read pipeline; storage lives in
// lb_mem_array.
//
// Parameters: DEPTH (>= 2), WIDTH (multiple of MASK_GRAN, <= LB_MAX_W), MASK_GRAN,
//             OUT_REG (1 adds a second read stage).
// Ports:
//   clock  single clock
//   reset  synchronous, active-high; clears valid bits and all read stages
//   bus    lb_mem_1r1w_if.slave (W0_*, R0_*, flush, R0_valid/R0_data/R0_hit)
//
// Build option: define LB_RW_BYPASS_EN to forward a same-cycle, same-address write
// to the read; otherwise such a read returns the pre-write entry.
module lb_mem_1r1w
  import lb_pkg::*;
#(
  parameter int unsigned DEPTH     = LB_DEPTH_DEF,
  parameter int unsigned WIDTH     = LB_WIDTH_DEF,
  parameter int unsigned MASK_GRAN = LB_MASK_GRAN_DEF,
  parameter int unsigned OUT_REG   = 0
) (
  input logic          clock,
  input logic          reset,
  lb_mem_1r1w_if.slave bus
);

  localparam int unsigned AW     = lb_addr_w(DEPTH);
  localparam int unsigned NLANES = WIDTH / MASK_GRAN;

  // ---------------------------------------------------------------------------
  // Valid bits and write path
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [NLANES-1:0] lane_mask;
  logic [WIDTH-1:0]  lane_bits;
  logic              w_in_range;
  logic              wr_fire;
  logic              wr_entry_valid;
  logic [WIDTH-1:0]  arr_wbit_en;
  logic [WIDTH-1:0]  arr_wdata;
  logic [WIDTH-1:0]  arr_rdata;

  assign lane_mask  = bus.W0_mask;
  assign lane_bits  = WIDTH'(lb_expand_mask(LB_MAX_W'(lane_mask), MASK_GRAN));
  assign w_in_range = 32'(bus.W0_addr) < DEPTH;
  assign wr_fire    = bus.W0_en & w_in_range;

  // A write coinciding with flush is treated as a write to an invalid entry.
  assign wr_entry_valid = valid_q[bus.W0_addr] & ~bus.flush;

  // Invalid entries are written in full so that unmasked lanes become zero;
  // valid entries only take the masked lanes.
  assign arr_wbit_en = wr_entry_valid ? lane_bits : '1;
  assign arr_wdata   = bus.W0_data & lane_bits;

  always_comb begin
    valid_d = bus.flush ? '0 : valid_q;
    if (wr_fire) begin
      valid_d[bus.W0_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  lb_mem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_array (
    .clock     (clock),
    .we_i      (wr_fire & ~reset),
    .waddr_i   (bus.W0_addr),
    .wbit_en_i (arr_wbit_en),
    .wdata_i   (arr_wdata),
    .raddr_i   (bus.R0_addr),
    .rdata_o   (arr_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read lookup (pre-edge state, so flush in the same cycle is not yet visible)
  // ---------------------------------------------------------------------------
  logic             r_in_range;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_data;

  assign r_in_range = 32'(bus.R0_addr) < DEPTH;

  always_comb begin
    rd_hit  = r_in_range & valid_q[bus.R0_addr];
    rd_data = rd_hit ? arr_rdata : '0;
`ifdef LB_RW_BYPASS_EN
    // Post-write view of the entry; arr_wbit_en already encodes the zero-fill case.
    if (wr_fire && (bus.R0_addr == bus.W0_addr)) begin
      rd_hit  = 1'b1;
      rd_data = (arr_rdata & ~arr_wbit_en) | arr_wdata;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: data/hit registers only load on a real read and hold otherwise.
  // ---------------------------------------------------------------------------
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             s1_hit_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_hit_q   <= 1'b0;
    end else begin
      s1_valid_q <= bus.R0_en;
      if (bus.R0_en) begin
        s1_data_q <= rd_data;
        s1_hit_q  <= rd_hit;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_hit_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_hit_q   <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
          s2_hit_q  <= s1_hit_q;
        end
      end
    end

    assign bus.R0_valid = s2_valid_q;
    assign bus.R0_data  = s2_data_q;
    assign bus.R0_hit   = s2_hit_q;
  end else begin : g_no_out_reg
    assign bus.R0_valid = s1_valid_q;
    assign bus.R0_data  = s1_data_q;
    assign bus.R0_hit   = s1_hit_q;
  end

endmodule

// File: tb/tb_lb_mem_1r1w.sv
// Self-checking bench for lb_mem_1r1w. Two instances share one stimulus stream:
// dut_a (DEPTH=32, OUT_REG=0) and dut_b (DEPTH=24, OUT_REG=1). A behavioural model
// (entry arrays plus a latency queue) predicts both outputs every cycle; literal
// expectations taken from hand calculation pin the model at key points.
module tb_lb_mem_1r1w;

  localparam int unsigned WIDTH   = 128;
  localparam int unsigned GRAN    = 8;
  localparam int unsigned NLANES  = WIDTH / GRAN;
  localparam int unsigned DEPTH_A = 32;
  localparam int unsigned DEPTH_B = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              w_en   = 1'b0;
  logic [4:0]        w_addr = '0;
  logic [WIDTH-1:0]  w_data = '0;
  logic [NLANES-1:0] w_mask = '0;
  logic              r_en   = 1'b0;
  logic [4:0]        r_addr = '0;
  logic              flush  = 1'b0;

  lb_mem_1r1w_if #(.DEPTH(DEPTH_A), .WIDTH(WIDTH), .MASK_GRAN(GRAN)) if_a ();
  lb_mem_1r1w_if #(.DEPTH(DEPTH_B), .WIDTH(WIDTH), .MASK_GRAN(GRAN)) if_b ();

  assign if_a.W0_en = w_en;   assign if_b.W0_en = w_en;
  assign if_a.W0_addr = w_addr; assign if_b.W0_addr = w_addr;
  assign if_a.W0_data = w_data; assign if_b.W0_data = w_data;
  assign if_a.W0_mask = w_mask; assign if_b.W0_mask = w_mask;
  assign if_a.R0_en = r_en;   assign if_b.R0_en = r_en;
  assign if_a.R0_addr = r_addr; assign if_b.R0_addr = r_addr;
  assign if_a.flush = flush;  assign if_b.flush = flush;

  lb_mem_1r1w #(.DEPTH(DEPTH_A), .WIDTH(WIDTH), .MASK_GRAN(GRAN), .OUT_REG(0)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (if_a)
  );

  lb_mem_1r1w #(.DEPTH(DEPTH_B), .WIDTH(WIDTH), .MASK_GRAN(GRAN), .OUT_REG(1)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (if_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  int pulses_b = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          dep [2] = '{DEPTH_A, DEPTH_B};
  int          lat [2] = '{1, 2};
  logic [WIDTH-1:0] m_data  [2][32];
  logic             m_valid [2][32];
  logic             p_v [2];
  logic [WIDTH-1:0] p_d [2];
  logic             p_h [2];
  logic             o_v [2];
  logic [WIDTH-1:0] o_d [2];
  logic             o_h [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_data[k][i]  = '0;
        m_valid[k][i] = 1'b0;
      end
    end
  end

  // Applies one clock edge to instance k's model using the currently driven inputs.
  task automatic model_edge(input int k);
    logic [WIDTH-1:0] rd, nd;
    logic             rh, nv, in_r, in_w, cur_v, cur_h;
    logic [WIDTH-1:0] cur_d;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_valid[k][i] = 1'b0;
      p_v[k] = 1'b0; p_d[k] = '0; p_h[k] = 1'b0;
      o_v[k] = 1'b0; o_d[k] = '0; o_h[k] = 1'b0;
      return;
    end
    in_r = int'(r_addr) < dep[k];
    in_w = int'(w_addr) < dep[k];
    rh = 1'b0;
    rd = '0;
    if (in_r && m_valid[k][r_addr]) begin
      rh = 1'b1;
      rd = m_data[k][r_addr];
    end
    nd = '0;
    if (w_en && in_w) begin
      nv = m_valid[k][w_addr] && !flush;
      for (int l = 0; l < NLANES; l++) begin
        if (w_mask[l])  nd[l*GRAN +: GRAN] = w_data[l*GRAN +: GRAN];
        else if (nv)    nd[l*GRAN +: GRAN] = m_data[k][w_addr][l*GRAN +: GRAN];
        else            nd[l*GRAN +: GRAN] = '0;
      end
`ifdef LB_RW_BYPASS_EN
      if (r_addr == w_addr) begin
        rd = nd;
        rh = 1'b1;
      end
`endif
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_valid[k][i] = 1'b0;
    end
    if (w_en && in_w) begin
      m_data[k][w_addr]  = nd;
      m_valid[k][w_addr] = 1'b1;
    end
    if (lat[k] == 1) begin
      cur_v = r_en; cur_d = rd; cur_h = rh;
    end else begin
      cur_v = p_v[k]; cur_d = p_d[k]; cur_h = p_h[k];
      p_v[k] = r_en; p_d[k] = rd; p_h[k] = rh;
    end
    o_v[k] = cur_v;
    if (cur_v) begin
      o_d[k] = cur_d;
      o_h[k] = cur_h;
    end
  endtask

  // One clock: update the model, advance, compare both DUTs, clear the inputs.
  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check("a_valid", WIDTH'(if_a.R0_valid), WIDTH'(o_v[0]));
    check("a_data",  if_a.R0_data,          o_d[0]);
    check("a_hit",   WIDTH'(if_a.R0_hit),   WIDTH'(o_h[0]));
    check("b_valid", WIDTH'(if_b.R0_valid), WIDTH'(o_v[1]));
    check("b_data",  if_b.R0_data,          o_d[1]);
    check("b_hit",   WIDTH'(if_b.R0_hit),   WIDTH'(o_h[1]));
    if (if_b.R0_valid === 1'b1) pulses_b++;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
  endtask

  task automatic set_wr(input logic [4:0] a, input logic [WIDTH-1:0] d,
                        input logic [NLANES-1:0] m);
    w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
  endtask

  task automatic set_rd(input logic [4:0] a);
    r_en = 1'b1; r_addr = a;
  endtask

  logic [WIDTH-1:0] all11, all22, all33, all44, all55, allab, exp9;

  initial begin
    all11 = {16{8'h11}};
    all22 = {16{8'h22}};
    all33 = {16{8'h33}};
    all44 = {16{8'h44}};
    all55 = {16{8'h55}};
    allab = {16{8'hAB}};
`ifdef LB_RW_BYPASS_EN
    exp9 = all33;
`else
    exp9 = all11;
`endif

    // Reset
    rst = 1'b1; step();
    rst = 1'b1; step();
    check("rst_a_valid", WIDTH'(if_a.R0_valid), '0);
    check("rst_b_data", if_b.R0_data, '0);

    // Reset then read addr 5
    set_rd(5'd5); step();
    check("rd5_a_valid", WIDTH'(if_a.R0_valid), WIDTH'(1));
    check("rd5_a_data", if_a.R0_data, '0);
    check("rd5_a_hit", WIDTH'(if_a.R0_hit), '0);
    step();
    check("rd5_b_valid", WIDTH'(if_b.R0_valid), WIDTH'(1));
    check("rd5_b_hit", WIDTH'(if_b.R0_hit), '0);

    // Partial write to invalid entry
    set_wr(5'd3, allab, 16'h0001); step();
    set_rd(5'd3); step();
    check("pw_a_data", if_a.R0_data, 128'hAB);
    check("pw_a_hit", WIDTH'(if_a.R0_hit), WIDTH'(1));
    step();
    check("pw_b_data", if_b.R0_data, 128'hAB);

    // Masked merge
    set_wr(5'd7, all11, 16'hFFFF); step();
    set_wr(5'd7, all22, 16'h8000); step();
    set_rd(5'd7); step();
    check("merge_a_data", if_a.R0_data, {8'h22, {15{8'h11}}});
    step();

    // Same-cycle read/write on addr 9
    set_wr(5'd9, all11, 16'hFFFF); step();
    set_wr(5'd9, all33, 16'hFFFF); set_rd(5'd9); step();
    check("rw9_a_data", if_a.R0_data, exp9);
    check("rw9_a_hit", WIDTH'(if_a.R0_hit), WIDTH'(1));
    step();
    check("rw9_b_data", if_b.R0_data, exp9);

    // Flush + write collision
    for (int i = 0; i < 4; i++) begin
      set_wr(5'(i), all55, 16'hFFFF); step();
    end
    flush = 1'b1; set_wr(5'd2, all44, 16'h0001); set_rd(5'd1); step();
    check("fl_pre_a_data", if_a.R0_data, all55);
    check("fl_pre_a_hit", WIDTH'(if_a.R0_hit), WIDTH'(1));
    set_rd(5'd0); step();
    check("fl0_a_data", if_a.R0_data, '0);
    check("fl0_a_hit", WIDTH'(if_a.R0_hit), '0);
    set_rd(5'd2); step();
    check("fl2_a_data", if_a.R0_data, 128'h44);
    check("fl2_a_hit", WIDTH'(if_a.R0_hit), WIDTH'(1));
    set_rd(5'd1); step();
    set_rd(5'd3); step();
    check("fl3_a_hit", WIDTH'(if_a.R0_hit), '0);
    step();

    // Zero-mask write still validates the entry
    set_wr(5'd12, all11, 16'h0000); step();
    set_rd(5'd12); step();
    check("m0_a_data", if_a.R0_data, '0);
    check("m0_a_hit", WIDTH'(if_a.R0_hit), WIDTH'(1));
    step();

    // Out-of-range write/read on the 24-deep instance
    set_wr(5'd31, {16{8'h66}}, 16'hFFFF); step();
    set_rd(5'd31); step();
    check("oor_b_valid_early", WIDTH'(if_b.R0_valid), '0);
    check("oor_a_hit", WIDTH'(if_a.R0_hit), WIDTH'(1));
    step();
    check("oor_b_valid", WIDTH'(if_b.R0_valid), WIDTH'(1));
    check("oor_b_data", if_b.R0_data, '0);
    check("oor_b_hit", WIDTH'(if_b.R0_hit), '0);

    // Back-to-back reads of every in-range entry
    pulses_b = 0;
    for (int i = 0; i < 24; i++) begin
      set_rd(5'(i)); step();
    end
    step();
    step();
    check("b2b_pulses", WIDTH'(pulses_b), WIDTH'(24));

    // Reset mid-stream discards outstanding reads
    set_rd(5'd0); step();
    set_rd(5'd1); step();
    pulses_b = 0;
    rst = 1'b1; set_rd(5'd2); step();
    step();
    step();
    check("rst_mid_pulses", WIDTH'(pulses_b), '0);
    set_rd(5'd3); step();
    check("post_rst_a_hit", WIDTH'(if_a.R0_hit), '0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
